// File: rtl/patch_mac_engine.sv
// Kernel-load / patch multiply-accumulate stage between the Xillybus write
// streams (kernel, patch) and the 32-bit read stream (saturated results).
module patch_mac_engine #(
    parameter int N_TAPS = 9,
    parameter int ACC_W  = 40
) (
    input  logic        bus_clk,
    input  logic        bus_rst_n,
    input  logic        kern_empty,
    output logic        kern_rden,
    input  logic [31:0] kern_data,
    input  logic        kern_open,
    input  logic        patch_empty,
    output logic        patch_rden,
    input  logic [31:0] patch_data,
    input  logic        patch_open,
    input  logic        res_full,
    output logic        res_wren,
    output logic [31:0] res_data,
    output logic        kernel_valid,
    output logic        busy,
    output logic [15:0] patch_count
);

    localparam int CNT_W = $clog2(N_TAPS + 2);
    localparam int IDX_W = $clog2(N_TAPS);
    localparam logic [CNT_W-1:0] N_PIX  = CNT_W'(N_TAPS);
    localparam logic [CNT_W-1:0] N_KERN = CNT_W'(N_TAPS + 1);
    localparam logic signed [ACC_W-1:0] ACC_MAX = {{(ACC_W-31){1'b0}}, {31{1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {{(ACC_W-31){1'b1}}, {31{1'b0}}};

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_MAC, S_OUT} state_t;
    state_t state, state_nxt;

    logic signed [15:0]      coef [N_TAPS];
    logic signed [31:0]      bias;
    logic [CNT_W-1:0]        iss_cnt, ret_cnt, acc_cnt;
    logic                    kern_ret, patch_ret, prod_vld;
    logic signed [31:0]      prod;
    logic signed [ACC_W-1:0] acc;
    logic [31:0]             acc_sat;
    logic                    bias_land;
    logic                    unused_patch_hi;

    // Pixel words carry data in the low half only.
    assign unused_patch_hi = ^patch_data[31:16];

    assign busy      = (state != S_IDLE);
    assign bias_land = (state == S_LOAD) && kern_open && kern_ret && (ret_cnt == N_PIX);

    always_comb begin
        // NOTE: every signal written here gets a default first, so no latch is inferred.
        state_nxt  = state;
        kern_rden  = 1'b0;
        patch_rden = 1'b0;
        res_wren   = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!kern_empty)                       state_nxt = S_LOAD;
                else if (kernel_valid && !patch_empty) state_nxt = S_MAC;
            end
            S_LOAD: begin
                if (!kern_open) begin
                    state_nxt = S_IDLE;
                end else begin
                    kern_rden = !kern_empty && (iss_cnt < N_KERN);
                    if (bias_land) state_nxt = S_IDLE;
                end
            end
            S_MAC: begin
                if (!patch_open) begin
                    state_nxt = S_IDLE;
                end else begin
                    patch_rden = !patch_empty && (iss_cnt < N_PIX);
                    if (acc_cnt == N_PIX) state_nxt = S_OUT;
                end
            end
            S_OUT: begin
                if (!patch_open) begin
                    state_nxt = S_IDLE;
                end else if (!res_full) begin
                    res_wren  = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (!bus_rst_n) state <= S_IDLE;
        else            state <= state_nxt;
    end

    // Counters are cleared in IDLE, so words from an aborted transfer never leak into the next one.
    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            iss_cnt      <= '0;
            ret_cnt      <= '0;
            acc_cnt      <= '0;
            kern_ret     <= 1'b0;
            patch_ret    <= 1'b0;
            prod_vld     <= 1'b0;
            kernel_valid <= 1'b0;
            res_data     <= '0;
            patch_count  <= '0;
        end else begin
            kern_ret  <= kern_rden;
            patch_ret <= patch_rden;
            prod_vld  <= patch_ret && (state == S_MAC);
            if (state == S_IDLE) begin
                iss_cnt <= '0;
                ret_cnt <= '0;
                acc_cnt <= '0;
            end else begin
                if (kern_rden || patch_rden) iss_cnt <= iss_cnt + 1'b1;
                if (kern_ret || patch_ret)   ret_cnt <= ret_cnt + 1'b1;
                if (prod_vld)                acc_cnt <= acc_cnt + 1'b1;
            end
            if (state == S_IDLE && state_nxt == S_LOAD) kernel_valid <= 1'b0;
            else if (bias_land)                         kernel_valid <= 1'b1;
            if (state == S_MAC && state_nxt == S_OUT) res_data <= acc_sat;
            if (res_wren) patch_count <= patch_count + 1'b1;
        end
    end

    always_ff @(posedge bus_clk or negedge bus_rst_n) begin
        if (!bus_rst_n) begin
            // NOTE: the coefficient store is reset explicitly because a zero kernel is part of the reset state.
            for (int i = 0; i < N_TAPS; i++) coef[i] <= '0;
            bias <= '0;
            prod <= '0;
            acc  <= '0;
        end else begin
            if (state == S_LOAD && kern_ret) begin
                if (ret_cnt < N_PIX) coef[ret_cnt[IDX_W-1:0]] <= kern_data[15:0];
                else                 bias <= kern_data;
            end
            if (patch_ret)
                prod <= 32'($signed(patch_data[15:0])) * 32'(coef[ret_cnt[IDX_W-1:0]]);
            if (state == S_IDLE)                 acc <= ACC_W'(bias);
            else if (state == S_MAC && prod_vld) acc <= acc + ACC_W'(prod);
        end
    end

    // The accumulator is wide enough never to wrap; clamping happens only here.
    always_comb begin
        if (acc > ACC_MAX)      acc_sat = 32'h7FFF_FFFF;
        else if (acc < ACC_MIN) acc_sat = 32'h8000_0000;
        else                    acc_sat = acc[31:0];
    end

endmodule

// File: tb/tb_patch_mac_engine.sv
// Self-checking bench for patch_mac_engine: FIFO models on all three streams,
// a dot-product reference model and a per-cycle monitor that scores every write.
module tb_patch_mac_engine;

    localparam int N_TAPS = 9;
    localparam int ACC_W  = 40;

    logic        bus_clk, bus_rst_n;
    logic        kern_empty, kern_rden, kern_open;
    logic [31:0] kern_data;
    logic        patch_empty, patch_rden, patch_open;
    logic [31:0] patch_data;
    logic        res_full, res_wren;
    logic [31:0] res_data;
    logic        kernel_valid, busy;
    logic [15:0] patch_count;

    patch_mac_engine #(.N_TAPS(N_TAPS), .ACC_W(ACC_W)) dut (
        .bus_clk(bus_clk), .bus_rst_n(bus_rst_n),
        .kern_empty(kern_empty), .kern_rden(kern_rden), .kern_data(kern_data), .kern_open(kern_open),
        .patch_empty(patch_empty), .patch_rden(patch_rden), .patch_data(patch_data), .patch_open(patch_open),
        .res_full(res_full), .res_wren(res_wren), .res_data(res_data),
        .kernel_valid(kernel_valid), .busy(busy), .patch_count(patch_count)
    );

    initial bus_clk = 1'b0;
    always #5 bus_clk = ~bus_clk;

    logic [31:0]        kq[$], pq[$], exp_q[$];
    int                 wren_cyc_q[$];
    logic signed [15:0] m_coef [N_TAPS];
    logic [31:0]        m_bias, last_res;
    logic [15:0]        m_count;
    int                 n_checks, n_fail, n_writes, cyc, last_prden_cyc;
    logic               k_pop, p_pop, full_hold, toggle_en, stall_en, full_rand_en, lat_chk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%h required=%h at t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] model_mac(input logic [31:0] px [N_TAPS]);
        longint s;
        s = longint'($signed(m_bias));
        for (int i = 0; i < N_TAPS; i++)
            s += longint'($signed(px[i][15:0])) * longint'(m_coef[i]);
        if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
        if (s < -64'sd2147483648) return 32'h8000_0000;
        return s[31:0];
    endfunction

    // FIFO models and scoreboard: inputs change on the falling edge, outputs are sampled 3 ns later.
    initial begin : fifo_monitor
        forever begin
            @(negedge bus_clk);
            cyc++;
            if (k_pop && kq.size() != 0) kern_data  = kq.pop_front();
            if (p_pop && pq.size() != 0) patch_data = pq.pop_front();
            kern_empty  = (kq.size() == 0);
            patch_empty = (pq.size() == 0) || (toggle_en && cyc[0]) ||
                          (stall_en && $urandom_range(0, 3) == 0);
            res_full    = full_hold || (full_rand_en && $urandom_range(0, 2) == 0);
            #3;
            k_pop = kern_rden;
            p_pop = patch_rden;
            if (kern_rden) check("kern_rden_while_empty", kern_empty, 0);
            if (patch_rden) begin
                check("patch_rden_while_empty", patch_empty, 0);
                check("patch_rden_without_kernel", kernel_valid, 1);
                last_prden_cyc = cyc;
            end
            if (res_wren) begin
                check("res_wren_while_full", res_full, 0);
                check("res_wren_expected", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) check("res_data", res_data, exp_q.pop_front());
                check("patch_count_at_write", patch_count, m_count);
                if (lat_chk) check("wren_latency", cyc - last_prden_cyc, 4);
                m_count++;
                n_writes++;
                last_res = res_data;
                wren_cyc_q.push_back(cyc);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(negedge bus_clk);
            #2;
        end
    endtask

    task automatic load_kernel(input logic [31:0] kw [N_TAPS+1]);
        for (int i = 0; i < N_TAPS; i++) begin
            kq.push_back(kw[i]);
            m_coef[i] = kw[i][15:0];
        end
        kq.push_back(kw[N_TAPS]);
        m_bias = kw[N_TAPS];
    endtask

    task automatic push_patch(input logic [31:0] px [N_TAPS]);
        for (int i = 0; i < N_TAPS; i++) pq.push_back(px[i]);
        exp_q.push_back(model_mac(px));
    endtask

    task automatic const_kernel(input logic [15:0] c, input logic [31:0] b);
        logic [31:0] kw [N_TAPS+1];
        logic [31:0] r;
        for (int i = 0; i < N_TAPS; i++) begin
            r = $urandom();
            kw[i] = {r[31:16], c};
        end
        kw[N_TAPS] = b;
        load_kernel(kw);
    endtask

    task automatic rand_kernel(input bit extreme);
        logic [31:0] kw [N_TAPS+1];
        for (int i = 0; i <= N_TAPS; i++) kw[i] = $urandom();
        if (extreme)
            for (int i = 0; i < N_TAPS; i++) kw[i][15:0] = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
        load_kernel(kw);
    endtask

    task automatic rand_patch(input bit extreme);
        logic [31:0] px [N_TAPS];
        for (int i = 0; i < N_TAPS; i++) begin
            px[i] = $urandom();
            if (extreme) px[i][15:0] = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8001;
        end
        push_patch(px);
    endtask

    task automatic wait_drain(input string name);
        int n;
        n = 0;
        while ((kq.size() != 0 || pq.size() != 0 || exp_q.size() != 0 || busy) && n < 3000) begin
            tick(1);
            n++;
        end
        check({name, "_drain_timeout"}, n < 3000, 1);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_kern_rden"},    kern_rden, 0);
        check({tag, "_patch_rden"},   patch_rden, 0);
        check({tag, "_res_wren"},     res_wren, 0);
        check({tag, "_res_data"},     res_data, 0);
        check({tag, "_kernel_valid"}, kernel_valid, 0);
        check({tag, "_busy"},         busy, 0);
        check({tag, "_patch_count"},  patch_count, 0);
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: actual=still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [31:0] px [N_TAPS];
        logic [31:0] r;
        int wr0, n, sz;

        bus_rst_n = 1'b0;
        kern_open = 1'b1; patch_open = 1'b1;
        kern_empty = 1'b1; patch_empty = 1'b1; res_full = 1'b0;
        kern_data = '0; patch_data = '0;
        k_pop = 1'b0; p_pop = 1'b0;
        full_hold = 1'b0; toggle_en = 1'b0; stall_en = 1'b0; full_rand_en = 1'b0; lat_chk = 1'b0;
        n_checks = 0; n_fail = 0; n_writes = 0; cyc = 0; last_prden_cyc = 0;
        m_count = '0; m_bias = '0; last_res = '0;
        for (int i = 0; i < N_TAPS; i++) m_coef[i] = '0;

        tick(3);
        check_reset_outputs("reset");
        bus_rst_n = 1'b1;
        tick(2);

        // Patch arrives before any kernel; ones kernel, bias 10, pixels 1..9.
        for (int i = 0; i < N_TAPS; i++) begin
            r = $urandom();
            px[i] = {r[31:16], 16'(i + 1)};
            pq.push_back(px[i]);
        end
        tick(20);
        check("patch_held_without_kernel", pq.size(), N_TAPS);
        check("no_kernel_valid_yet", kernel_valid, 0);
        lat_chk = 1'b1;
        const_kernel(16'h0001, 32'd10);
        exp_q.push_back(model_mac(px));
        check("model_pin_55", model_mac(px), 32'd55);
        wait_drain("ones");
        check("ones_result", last_res, 32'd55);
        check("ones_count", patch_count, 1);
        check("ones_kernel_valid", kernel_valid, 1);

        // Positive and negative saturation.
        const_kernel(16'h7FFF, 32'h7FFF_FFFF);
        wait_drain("sat_hi_kernel");
        for (int i = 0; i < N_TAPS; i++) px[i] = 32'h0000_7FFF;
        check("model_pin_sat_hi", model_mac(px), 32'h7FFF_FFFF);
        push_patch(px);
        wait_drain("sat_hi");
        check("sat_hi_result", last_res, 32'h7FFF_FFFF);
        const_kernel(16'h7FFF, 32'h8000_0000);
        wait_drain("sat_lo_kernel");
        for (int i = 0; i < N_TAPS; i++) px[i] = 32'hFFFF_8001;
        check("model_pin_sat_lo", model_mac(px), 32'h8000_0000);
        push_patch(px);
        wait_drain("sat_lo");
        check("sat_lo_result", last_res, 32'h8000_0000);

        // Back-to-back patches: one result every N_TAPS+5 cycles.
        rand_kernel(1'b0);
        wait_drain("b2b_kernel");
        for (int k = 0; k < 3; k++) rand_patch(1'b0);
        wait_drain("b2b");
        sz = wren_cyc_q.size();
        check("b2b_interval_1", wren_cyc_q[sz-1] - wren_cyc_q[sz-2], N_TAPS + 5);
        check("b2b_interval_2", wren_cyc_q[sz-2] - wren_cyc_q[sz-3], N_TAPS + 5);

        // Empty toggling during MAC, result FIFO full for a long stretch.
        lat_chk = 1'b0; toggle_en = 1'b1; full_hold = 1'b1;
        wr0 = n_writes;
        rand_patch(1'b0);
        tick(40);
        check("full_hold_no_write", n_writes, wr0);
        check("full_hold_busy", busy, 1);
        full_hold = 1'b0;
        wait_drain("stall");
        check("stall_one_write", n_writes, wr0 + 1);
        toggle_en = 1'b0; lat_chk = 1'b1;

        // Patch stream closed after 4 words.
        wr0 = n_writes;
        for (int i = 0; i < 4; i++) pq.push_back($urandom());
        n = 0;
        while (pq.size() != 0 && n < 200) begin tick(1); n++; end
        check("abort_words_taken", pq.size(), 0);
        tick(6);
        patch_open = 1'b0;
        tick(4);
        check("abort_busy", busy, 0);
        check("abort_count", patch_count, m_count);
        check("abort_no_write", n_writes, wr0);
        patch_open = 1'b1;
        rand_patch(1'b0);
        wait_drain("after_abort");
        check("after_abort_write", n_writes, wr0 + 1);

        // Kernel stream closed mid-load: patches must wait for a full reload.
        for (int i = 0; i < 5; i++) kq.push_back($urandom());
        n = 0;
        while (kq.size() != 0 && n < 200) begin tick(1); n++; end
        tick(4);
        kern_open = 1'b0;
        tick(3);
        check("kabort_kernel_valid", kernel_valid, 0);
        check("kabort_busy", busy, 0);
        kern_open = 1'b1;
        for (int i = 0; i < N_TAPS; i++) begin
            px[i] = $urandom();
            pq.push_back(px[i]);
        end
        tick(15);
        check("kabort_patch_held", pq.size(), N_TAPS);
        rand_kernel(1'b0);
        exp_q.push_back(model_mac(px));
        wait_drain("kabort_reload");

        // Asynchronous reset in the middle of a patch.
        rand_patch(1'b0);
        tick(4);
        check("pre_reset_busy", busy, 1);
        bus_rst_n = 1'b0;
        #1;
        check_reset_outputs("midreset");
        #1;
        kq.delete(); pq.delete(); exp_q.delete();
        k_pop = 1'b0; p_pop = 1'b0; m_count = '0;
        tick(2);
        bus_rst_n = 1'b1;
        tick(1);
        rand_kernel(1'b0);
        wait_drain("post_reset_kernel");
        rand_patch(1'b0);
        wait_drain("post_reset");
        check("post_reset_count", patch_count, 1);

        // Randomised kernels, patches, stalls and back-pressure.
        lat_chk = 1'b0; stall_en = 1'b1; full_rand_en = 1'b1;
        for (int k = 0; k < 6; k++) begin
            rand_kernel(k % 3 == 2);
            wait_drain("rand_kernel");
            for (int p = 0; p < 4; p++) rand_patch(k % 3 == 2 && p % 2 == 0);
            wait_drain("rand_patches");
        end
        stall_en = 1'b0; full_rand_en = 1'b0;
        check("final_count", patch_count, m_count);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
